// File: rtl/icache_mem_arbiter_pkg.sv
// Shared definitions for the instruction-cache miss arbiter: default widths,
// request-stage state encoding and the {port, source} tag layout that the L2
// side also uses to interpret source bits.
package icache_mem_arbiter_pkg;

  // Default widths: warp-id bits, XLEN and (block words * XLEN).
  localparam int unsigned DefSrcW  = 4;
  localparam int unsigned DefAddrW = 32;
  localparam int unsigned DefDataW = 128;

  typedef enum logic {StEmpty, StFull} req_state_e;

  // Width of the port index carried in the tag; never narrower than one bit.
  function automatic int unsigned port_bits(int unsigned num_port);
    return (num_port > 1) ? $clog2(num_port) : 1;
  endfunction

  // Tag layout: {port, source}. Source sits at bit 0, the port right above it.
  function automatic int unsigned tag_src_lsb();
    return 0;
  endfunction

  function automatic int unsigned tag_port_lsb(int unsigned src_w);
    return src_w;
  endfunction

endpackage

// File: rtl/icache_mem_arbiter_rr_arbiter.sv
// Combinational round-robin search: first valid port at or after ptr_i,
// wrapping modulo NUM_PORT. Returns one-hot and binary grant.
module icache_mem_arbiter_rr_arbiter
  import icache_mem_arbiter_pkg::*;
#(
  parameter int unsigned NUM_PORT  = 2,
  parameter int unsigned PORT_BITS = port_bits(NUM_PORT)
) (
  input  logic [NUM_PORT-1:0]  valid_i,
  input  logic [PORT_BITS-1:0] ptr_i,
  output logic [NUM_PORT-1:0]  grant_o,
  output logic [PORT_BITS-1:0] grant_idx_o,
  output logic                 any_o
);

  // Walk offsets from farthest to nearest so the nearest valid port wins.
  always_comb begin
    int idx;
    grant_o     = '0;
    grant_idx_o = '0;
    any_o       = |valid_i;
    for (int i = int'(NUM_PORT) - 1; i >= 0; i--) begin
      idx = (int'(ptr_i) + i) % int'(NUM_PORT);
      if (valid_i[idx]) begin
        grant_o      = '0;
        grant_o[idx] = 1'b1;
        grant_idx_o  = PORT_BITS'(idx);
      end
    end
  end

endmodule

// File: rtl/icache_mem_arbiter.sv
// Round-robin arbiter sharing one L2 miss-request channel among NUM_PORT
// instruction caches. Requests are tagged {port, source} and held in a
// one-entry register stage; refills are routed back on the port tag.
// Optional feature macro: ICACHE_ARB_RSP_SLICE_EN adds a one-entry register
// slice on the response path (default build: combinational response path).
module icache_mem_arbiter
  import icache_mem_arbiter_pkg::*;
#(
  parameter int unsigned NUM_PORT  = 2,
  parameter int unsigned PORT_BITS = port_bits(NUM_PORT),
  parameter int unsigned SRC_W     = DefSrcW,
  parameter int unsigned ADDR_W    = DefAddrW,
  parameter int unsigned DATA_W    = DefDataW
) (
  input  logic                          clk,
  input  logic                          rst_n,
  // Per-port miss requests
  input  logic [NUM_PORT-1:0]           in_req_valid_i,
  output logic [NUM_PORT-1:0]           in_req_ready_o,
  input  logic [NUM_PORT*SRC_W-1:0]     in_req_source_i,
  input  logic [NUM_PORT*ADDR_W-1:0]    in_req_addr_i,
  // Shared L2 request
  output logic                          out_req_valid_o,
  input  logic                          out_req_ready_i,
  output logic [PORT_BITS+SRC_W-1:0]    out_req_source_o,
  output logic [ADDR_W-1:0]             out_req_addr_o,
  // L2 refill
  input  logic                          out_rsp_valid_i,
  output logic                          out_rsp_ready_o,
  input  logic [PORT_BITS+SRC_W-1:0]    out_rsp_source_i,
  input  logic [ADDR_W-1:0]             out_rsp_addr_i,
  input  logic [DATA_W-1:0]             out_rsp_data_i,
  // Per-port refill
  output logic [NUM_PORT-1:0]           in_rsp_valid_o,
  input  logic [NUM_PORT-1:0]           in_rsp_ready_i,
  output logic [SRC_W-1:0]              in_rsp_source_o,
  output logic [ADDR_W-1:0]             in_rsp_addr_o,
  output logic [DATA_W-1:0]             in_rsp_data_o
);

  localparam int unsigned PortLsb = tag_port_lsb(SRC_W);
  localparam int unsigned SrcLsb  = tag_src_lsb();

  // ---------------------------------------------------------------------------
  // Request path
  // ---------------------------------------------------------------------------
  req_state_e                 state_q;
  logic [PORT_BITS-1:0]       rr_q;
  logic [PORT_BITS+SRC_W-1:0] src_q;
  logic [ADDR_W-1:0]          addr_q;

  logic                       load;
  logic [NUM_PORT-1:0]        grant;
  logic [PORT_BITS-1:0]       grant_idx;
  logic                       grant_any;
  logic [SRC_W-1:0]           grant_src;
  logic [ADDR_W-1:0]          grant_addr;
  logic [PORT_BITS-1:0]       rr_next;

  icache_mem_arbiter_rr_arbiter #(
    .NUM_PORT  (NUM_PORT),
    .PORT_BITS (PORT_BITS)
  ) u_rr_arbiter (
    .valid_i     (in_req_valid_i),
    .ptr_i       (rr_q),
    .grant_o     (grant),
    .grant_idx_o (grant_idx),
    .any_o       (grant_any)
  );

  // Accept decision, granted payload mux and next pointer.
  always_comb begin
    load           = (state_q == StEmpty) || out_req_ready_i;
    // Ready is held low while reset is asserted so nothing appears accepted.
    in_req_ready_o = (load && rst_n) ? grant : '0;
    grant_src      = '0;
    grant_addr     = '0;
    for (int i = 0; i < int'(NUM_PORT); i++) begin
      if (grant[i]) begin
        grant_src  = in_req_source_i[i*SRC_W +: SRC_W];
        grant_addr = in_req_addr_i[i*ADDR_W +: ADDR_W];
      end
    end
    rr_next = (int'(grant_idx) == int'(NUM_PORT) - 1) ? '0 : grant_idx + PORT_BITS'(1);
  end

  // Request-stage FSM: EMPTY/FULL with registered payload and rr pointer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StEmpty;
      rr_q    <= '0;
      src_q   <= '0;
      addr_q  <= '0;
    end else if (load) begin
      if (grant_any) begin
        state_q <= StFull;
        src_q   <= {grant_idx, grant_src};
        addr_q  <= grant_addr;
        rr_q    <= rr_next;
      end else begin
        state_q <= StEmpty;
      end
    end
  end

  assign out_req_valid_o  = (state_q == StFull);
  assign out_req_source_o = src_q;
  assign out_req_addr_o   = addr_q;

  // ---------------------------------------------------------------------------
  // Response path
  // ---------------------------------------------------------------------------
  logic [PORT_BITS-1:0] rsp_port;
  assign rsp_port = out_rsp_source_i[PortLsb +: PORT_BITS];

`ifdef ICACHE_ARB_RSP_SLICE_EN
  logic                 rsp_legal;
  logic                 slice_valid_q;
  logic [PORT_BITS-1:0] slice_port_q;
  logic [SRC_W-1:0]     slice_src_q;
  logic [ADDR_W-1:0]    slice_addr_q;
  logic [DATA_W-1:0]    slice_data_q;
  logic                 slice_port_ready;

  // Slice output routing and upstream ready.
  always_comb begin
    rsp_legal        = int'(rsp_port) < int'(NUM_PORT);
    slice_port_ready = 1'b0;
    in_rsp_valid_o   = '0;
    for (int i = 0; i < int'(NUM_PORT); i++) begin
      if (int'(slice_port_q) == i) begin
        slice_port_ready  = in_rsp_ready_i[i];
        in_rsp_valid_o[i] = slice_valid_q;
      end
    end
    out_rsp_ready_o = !slice_valid_q || slice_port_ready;
  end

  // One-entry slice; illegal-port beats are accepted but never loaded.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slice_valid_q <= 1'b0;
      slice_port_q  <= '0;
      slice_src_q   <= '0;
      slice_addr_q  <= '0;
      slice_data_q  <= '0;
    end else if (out_rsp_valid_i && out_rsp_ready_o && rsp_legal) begin
      slice_valid_q <= 1'b1;
      slice_port_q  <= rsp_port;
      slice_src_q   <= out_rsp_source_i[SrcLsb +: SRC_W];
      slice_addr_q  <= out_rsp_addr_i;
      slice_data_q  <= out_rsp_data_i;
    end else if (slice_valid_q && slice_port_ready) begin
      slice_valid_q <= 1'b0;
    end
  end

  assign in_rsp_source_o = slice_src_q;
  assign in_rsp_addr_o   = slice_addr_q;
  assign in_rsp_data_o   = slice_data_q;
`else
  // Combinational routing; an out-of-range port matches nothing, so the beat
  // is acked and dropped.
  always_comb begin
    in_rsp_valid_o  = '0;
    out_rsp_ready_o = 1'b1;
    for (int i = 0; i < int'(NUM_PORT); i++) begin
      if (int'(rsp_port) == i) begin
        in_rsp_valid_o[i] = out_rsp_valid_i;
        out_rsp_ready_o   = in_rsp_ready_i[i];
      end
    end
  end

  assign in_rsp_source_o = out_rsp_source_i[SrcLsb +: SRC_W];
  assign in_rsp_addr_o   = out_rsp_addr_i;
  assign in_rsp_data_o   = out_rsp_data_i;
`endif

endmodule
